// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the block loader state encoding.
package sha256_pkg;

  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_WORD_W  = 32;
  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EMIT,
    ST_EXTRA,
    ST_EMIT_FINAL
  } loader_state_e;

endpackage

// File: rtl/sha256_pad_word.sv
// Keeps the first nbytes_i bytes of a big-endian word, clears the rest and
// optionally drops the 0x80 marker into the first free byte.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] word_i,
  input  logic [2:0]               nbytes_i,
  input  logic                     insert_marker_i,
  output logic [SHA256_WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes_i) begin
        word_o[31-8*b -: 8] = word_i[31-8*b -: 8];
      end else if (insert_marker_i && (3'(b) == nbytes_i)) begin
        word_o[31-8*b -: 8] = SHA256_PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha256_block_loader.sv
// Packs a big-endian 32-bit word stream into FIPS 180-4 padded 512-bit
// blocks and presents them one at a time on a valid/ready output.
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [SHA256_WORD_W-1:0]  in_data_i,
  input  logic                      in_last_i,
  input  logic [2:0]                in_bytes_i,
  output logic                      blk_valid_o,
  input  logic                      blk_ready_i,
  output logic [SHA256_BLOCK_W-1:0] blk_out_o,
  output logic                      blk_first_o,
  output logic                      blk_final_o
);

  localparam int NW = SHA256_BLOCK_W / SHA256_WORD_W;

  loader_state_e state_q, state_d;

  logic [3:0]                idx_q, idx_d;
  logic [LEN_W-1:0]          bitLen_q, bitLen_d;
  logic [SHA256_WORD_W-1:0]  buf_q [NW];
  logic [SHA256_WORD_W-1:0]  buf_d [NW];
  logic                      firstFlag_q, firstFlag_d;
  logic                      pendExtra_q, pendExtra_d;
  logic                      extraMarker_q, extraMarker_d;
  logic                      inReady_q;
  logic                      blkValid_q, blkValid_d;
  logic [SHA256_BLOCK_W-1:0] blkOut_q, blkOut_d;
  logic                      blkFirst_q, blkFirst_d;
  logic                      blkFinal_q, blkFinal_d;

  logic                      inFire, outFire;
  logic [2:0]                effBytes;
  logic [6:0]                markerPos;
  logic                      lastFits;
  logic [LEN_W-1:0]          bitLenNext;
  logic [63:0]               lenNext, lenCur;
  logic [SHA256_WORD_W-1:0]  paddedWord;
  logic [SHA256_BLOCK_W-1:0] assembled;

  assign inFire     = in_valid_i && inReady_q;
  assign outFire    = blkValid_q && blk_ready_i;
  assign effBytes   = (!in_last_i || (in_bytes_i > 3'd4)) ? 3'd4 : in_bytes_i;
  assign markerPos  = {1'b0, idx_q, 2'b00} + {4'b0000, effBytes};
  assign lastFits   = (markerPos <= 7'd55);
  assign bitLenNext = bitLen_q + LEN_W'({effBytes, 3'b000});
  assign lenNext    = 64'(bitLenNext);
  assign lenCur     = 64'(bitLen_q);

  sha256_pad_word u_pad (
    .word_i          (in_data_i),
    .nbytes_i        (effBytes),
    .insert_marker_i (in_last_i),
    .word_o          (paddedWord)
  );

  // Block as it would look if the word on the input were accepted now.
  // A full last word pushes the marker into the following slot.
  always_comb begin
    assembled = '0;
    for (int k = 0; k < NW; k++) begin
      if (4'(k) < idx_q) begin
        assembled[SHA256_BLOCK_W-1-SHA256_WORD_W*k -: SHA256_WORD_W] = buf_q[k];
      end else if (4'(k) == idx_q) begin
        assembled[SHA256_BLOCK_W-1-SHA256_WORD_W*k -: SHA256_WORD_W] = paddedWord;
      end else if (in_last_i && (effBytes == 3'd4) && (4'(k) == idx_q + 4'd1)) begin
        assembled[SHA256_BLOCK_W-1-SHA256_WORD_W*k -: SHA256_WORD_W] = {SHA256_PAD_BYTE, 24'h0};
      end
    end
    if (in_last_i && lastFits) begin
      assembled[63:0] = lenNext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (inFire) begin
          if (in_last_i) begin
            state_d = lastFits ? ST_EMIT_FINAL : ST_EMIT;
          end else if (idx_q == 4'd15) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (outFire) begin
          state_d = pendExtra_q ? ST_EXTRA : ST_FILL;
        end
      end
      ST_EXTRA: state_d = ST_EMIT_FINAL;
      ST_EMIT_FINAL: begin
        if (outFire) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Output register loads on the accepting edge so blk_valid follows one cycle later.
  always_comb begin
    idx_d         = idx_q;
    bitLen_d      = bitLen_q;
    buf_d         = buf_q;
    firstFlag_d   = firstFlag_q;
    pendExtra_d   = pendExtra_q;
    extraMarker_d = extraMarker_q;
    blkValid_d    = blkValid_q;
    blkOut_d      = blkOut_q;
    blkFirst_d    = blkFirst_q;
    blkFinal_d    = blkFinal_q;

    if (outFire) begin
      blkValid_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (inFire) begin
          bitLen_d       = bitLenNext;
          idx_d          = idx_q + 4'd1;
          buf_d[idx_q]   = in_data_i;
          if (in_last_i || (idx_q == 4'd15)) begin
            blkValid_d    = 1'b1;
            blkOut_d      = assembled;
            blkFirst_d    = firstFlag_q;
            blkFinal_d    = in_last_i && lastFits;
            firstFlag_d   = 1'b0;
            pendExtra_d   = in_last_i && !lastFits;
            extraMarker_d = (markerPos == 7'd64);
          end
        end
      end
      ST_EXTRA: begin
        blkValid_d  = 1'b1;
        blkOut_d    = {(extraMarker_q ? SHA256_PAD_BYTE : 8'h00), 440'h0, lenCur};
        blkFirst_d  = firstFlag_q;
        blkFinal_d  = 1'b1;
        pendExtra_d = 1'b0;
      end
      ST_EMIT_FINAL: begin
        if (outFire) begin
          bitLen_d    = '0;
          idx_d       = '0;
          firstFlag_d = 1'b1;
          for (int k = 0; k < NW; k++) begin
            buf_d[k] = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q         <= '0;
      bitLen_q      <= '0;
      for (int k = 0; k < NW; k++) begin
        buf_q[k] <= '0;
      end
      firstFlag_q   <= 1'b1;
      pendExtra_q   <= 1'b0;
      extraMarker_q <= 1'b0;
      inReady_q     <= 1'b1;
      blkValid_q    <= 1'b0;
      blkOut_q      <= '0;
      blkFirst_q    <= 1'b0;
      blkFinal_q    <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      bitLen_q      <= bitLen_d;
      for (int k = 0; k < NW; k++) begin
        buf_q[k] <= buf_d[k];
      end
      firstFlag_q   <= firstFlag_d;
      pendExtra_q   <= pendExtra_d;
      extraMarker_q <= extraMarker_d;
      inReady_q     <= (state_d == ST_FILL);
      blkValid_q    <= blkValid_d;
      blkOut_q      <= blkOut_d;
      blkFirst_q    <= blkFirst_d;
      blkFinal_q    <= blkFinal_d;
    end
  end

  assign in_ready_o  = inReady_q;
  assign blk_valid_o = blkValid_q;
  assign blk_out_o   = blkOut_q;
  assign blk_first_o = blkFirst_q;
  assign blk_final_o = blkFinal_q;

endmodule

// File: tb/tb_sha256_block_loader.sv
// Bench for sha256_block_loader: a byte-level padding model predicts every
// block; a compare process checks the DUT against it on each valid cycle.
module tb_sha256_block_loader;

  typedef logic [7:0] byteq_t[$];
  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic [511:0] blk_out;
  logic         blk_first;
  logic         blk_final;

  blk_t expQ[$];
  blk_t gotQ[$];
  int   assertCount = 0;
  int   failCount = 0;
  bit   bDone;

  sha256_block_loader #(.LEN_W(64)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_bytes_i  (in_bytes),
    .blk_valid_o (blk_valid),
    .blk_ready_i (blk_ready),
    .blk_out_o   (blk_out),
    .blk_first_o (blk_first),
    .blk_final_o (blk_final)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard SHA-256 padding applied to the whole byte string, then chopped into blocks.
  function automatic void modelPush(input byteq_t msg);
    byteq_t p;
    logic [63:0] bl;
    int nblk;
    blk_t e;
    p = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int i = 0; i < 64; i++) e.data[511-8*i -: 8] = p[64*b+i];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      expQ.push_back(e);
    end
  endfunction

  function automatic byteq_t mkMsg(input int n, input int seed);
    byteq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'((seed + 7 * i) & 255));
    return q;
  endfunction

  task automatic sendWord(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waitCycles++;
      if (waitCycles >= 200) begin
        checkOutput("in_ready timeout", 512'(in_ready), 512'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Unused byte lanes carry junk and non-last words carry a bogus in_bytes.
  task automatic applyStimulus(input byteq_t msg);
    int nWords;
    int rem;
    logic [31:0] w;
    logic lastW;
    modelPush(msg);
    nWords = (msg.size() + 3) / 4;
    if (nWords == 0) nWords = 1;
    for (int i = 0; i < nWords; i++) begin
      w = 32'hA5A5A5A5;
      rem = msg.size() - 4 * i;
      for (int b = 0; b < 4; b++) if (b < rem) w[31-8*b -: 8] = msg[4*i+b];
      lastW = (i == nWords - 1);
      sendWord(w, lastW, lastW ? 3'(rem) : 3'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain pending blocks", 512'(expQ.size()), 512'd0);
  endtask

  initial begin : compareProc
    blk_t g;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && blk_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected block", 512'(blk_valid), 512'd0);
        end else begin
          checkOutput("blk_out", blk_out, expQ[0].data);
          checkOutput("blk_first", 512'(blk_first), 512'(expQ[0].first));
          checkOutput("blk_final", 512'(blk_final), 512'(expQ[0].last));
          if (blk_ready === 1'b1) begin
            g.data  = blk_out;
            g.first = blk_first;
            g.last  = blk_final;
            gotQ.push_back(g);
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainProc
    byteq_t m;
    byteq_t mB;

    #23;
    checkOutput("reset in_ready", 512'(in_ready), 512'd1);
    checkOutput("reset blk_valid", 512'(blk_valid), 512'd0);
    checkOutput("reset blk_out", blk_out, 512'd0);
    checkOutput("reset blk_first", 512'(blk_first), 512'd0);
    checkOutput("reset blk_final", 512'(blk_final), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    m = '{8'h61, 8'h62, 8'h63};
    applyStimulus(m);
    @(negedge clk);
    checkOutput("abc latency", 512'(blk_valid), 512'd1);
    waitDrain();
    checkOutput("abc count", 512'(gotQ.size()), 512'd1);
    checkOutput("abc literal", gotQ[0].data, {32'h61626380, 448'h0, 32'h00000018});
    checkOutput("abc flags", 512'({gotQ[0].first, gotQ[0].last}), 512'd3);
    gotQ.delete();

    m.delete();
    applyStimulus(m);
    waitDrain();
    checkOutput("empty literal", gotQ[0].data, {32'h80000000, 480'h0});
    checkOutput("empty flags", 512'({gotQ[0].first, gotQ[0].last}), 512'd3);
    gotQ.delete();

    applyStimulus(mkMsg(56, 3));
    waitDrain();
    checkOutput("56B count", 512'(gotQ.size()), 512'd2);
    checkOutput("56B blk1 W14W15", 512'(gotQ[0].data[63:0]), 512'({32'h80000000, 32'h0}));
    checkOutput("56B blk1 flags", 512'({gotQ[0].first, gotQ[0].last}), 512'd2);
    checkOutput("56B blk2 literal", gotQ[1].data, {480'h0, 32'h000001C0});
    checkOutput("56B blk2 flags", 512'({gotQ[1].first, gotQ[1].last}), 512'd1);
    gotQ.delete();

    applyStimulus(mkMsg(64, 5));
    @(negedge clk);
    checkOutput("64B blk1 valid", 512'(blk_valid), 512'd1);
    @(negedge clk);
    checkOutput("64B extra gap", 512'(blk_valid), 512'd0);
    @(negedge clk);
    checkOutput("64B extra valid", 512'(blk_valid), 512'd1);
    waitDrain();
    checkOutput("64B count", 512'(gotQ.size()), 512'd2);
    checkOutput("64B blk2 literal", gotQ[1].data, {32'h80000000, 448'h0, 32'h00000200});
    gotQ.delete();

    applyStimulus(mkMsg(60, 9));
    waitDrain();
    applyStimulus(mkMsg(61, 13));
    waitDrain();
    applyStimulus(mkMsg(70, 17));
    waitDrain();
    gotQ.delete();

    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    m = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
    applyStimulus(m);
    mB = mkMsg(9, 11);
    bDone = 1'b0;
    fork
      begin
        applyStimulus(mB);
        bDone = 1'b1;
      end
    join_none
    repeat (10) begin
      @(negedge clk);
      checkOutput("hold in_ready", 512'(in_ready), 512'd0);
      checkOutput("hold blk_valid", 512'(blk_valid), 512'd1);
    end
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    begin
      int n = 0;
      while (!bDone && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("hold second message sent", 512'(bDone), 512'd1);
    waitDrain();
    checkOutput("hold count", 512'(gotQ.size()), 512'd2);
    checkOutput("hold literal", gotQ[0].data, {32'h68656c6c, 32'h6f800000, 416'h0, 32'h00000028});
    gotQ.delete();

    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) sendWord(32'(i) * 32'h01020304, 1'b0, 3'd4);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst in_ready", 512'(in_ready), 512'd1);
    checkOutput("async rst blk_valid", 512'(blk_valid), 512'd0);
    checkOutput("async rst blk_out", blk_out, 512'd0);
    checkOutput("async rst blk_first", 512'(blk_first), 512'd0);
    checkOutput("async rst blk_final", 512'(blk_final), 512'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m = '{8'h61, 8'h62, 8'h63};
    applyStimulus(m);
    waitDrain();
    checkOutput("post-reset abc count", 512'(gotQ.size()), 512'd1);
    checkOutput("post-reset abc literal", gotQ[0].data, {32'h61626380, 448'h0, 32'h00000018});
    checkOutput("post-reset abc flags", 512'({gotQ[0].first, gotQ[0].last}), 512'd3);
    gotQ.delete();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sha256_block_loader.md
# sha256_block_loader

- Assembles a byte-aligned message into padded 512-bit SHA-256 blocks.
- Input is a 32-bit big-endian word stream with valid/ready handshake. Output is one block at a time, with valid/ready handshake.
- Sits upstream of the message-schedule pipeline. Its `blk_out` word order matches that pipeline's `block_in`: W0 at [511:480], W15 at [31:0].
- Implements FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit big-endian bit length.

## Interface
- `LEN_W`, default 64: width of the bit-length counter. Must be 64 for standard SHA-256; the length field is always 64 bits, zero-extended.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: loader can accept a word.
- `in_data` in 32: message word, first byte in [31:24].
- `in_last` in 1: this word ends the message.
- `in_bytes` in 3: valid bytes in a last word, 0..4. Ignored (treated as 4) when `in_last`=0. Values above 4 are treated as 4. Value 0 is legal only with `in_last`, for example an empty message.
- `blk_valid` out 1: `blk_out` holds a complete block.
- `blk_ready` in 1: consumer accepts the block.
- `blk_out` out 512: padded block.
- `blk_first` out 1: block is the first of its message.
- `blk_final` out 1: block is the last of its message.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `blk_valid && blk_ready`.
- States:
  - FILL: accept words into buffer slot `idx` (0..15).
  - EMIT: present block, `in_ready`=0.
  - EXTRA: build the length-only or marker-plus-length block.
  - EMIT_FINAL: present the last block.
- FILL, non-last word:
  - Write the word to slot `idx`, add 32 to `bitlen`, then `idx++`.
  - On `idx`=15 → EMIT. After the handshake, return to FILL with `idx`=0.
- FILL, last word:
  - Valid bytes are kept and the remaining bytes of the word are cleared.
  - Marker byte position `p` = `idx`*4 + `in_bytes` (byte offset in the block).
  - `bitlen` += 8·`in_bytes`.
  - If `p` ≤ 55: write 0x80 at byte `p`, zero bytes `p`+1..55, write `bitlen` to bytes 56..63, then → EMIT_FINAL.
  - If 56 ≤ `p` ≤ 63: write 0x80 at `p`, zero the rest, → EMIT. Then → EXTRA, whose block is all zero plus `bitlen` in bytes 56..63.
  - If `p` = 64: current block → EMIT. The EXTRA block is 0x80 at byte 0, zeros, then `bitlen`.
- EXTRA: one cycle to load the block, then → EMIT_FINAL.
- EMIT_FINAL: after the handshake, clear `bitlen`, `idx`, and the buffer, and set the first-flag. Then → FILL.
- `blk_first` is set on the first block of each message. `blk_final` is set only in EMIT_FINAL. A one-block message has both set.
- `bitlen` wraps modulo 2^`LEN_W`; no error is flagged.
- Output stability: while `blk_valid`=1 and `blk_ready`=0, `blk_out`, `blk_first` and `blk_final` hold constant.

## Timing
- Reset values: `in_ready`=1, `blk_valid`=0, `blk_out`=0, `blk_first`=0, `blk_final`=0. Internal state: FILL, `idx`=0, `bitlen`=0, first-flag=1.
- `blk_valid` rises in the cycle after the accepting edge of the 16th or last word.
- The EXTRA block is valid 2 cycles after the preceding block's handshake: one cycle in EXTRA, one registered.
- `in_ready`=1 only in FILL, so there is no overlap between fill and emit. Throughput is 16 words plus 1 cycle per block at full rate with `blk_ready` tied high.
- `in_ready` is registered and does not depend combinationally on `blk_ready`.
- Reset asserted at any point aborts the message immediately. There is no partial block output, and the next message starts fresh.

## Structure
- Shared package `sha256_pkg` holds:
  - `SHA256_BLOCK_W`=512 and `SHA256_WORD_W`=32.
  - `SHA256_PAD_BYTE`=8'h80.
  - The loader state enum.
- Sub-module `sha256_pad_word` (combinational): given `word`, `nbytes` (0..4) and `insert_marker`, returns the word with bytes ≥`nbytes` zeroed and 0x80 at byte `nbytes` when `nbytes`<4.
- Top level holds the FSM, the 16×32 buffer, `idx`, `bitlen` and the output register.

## Test plan
- Message "abc" (one word 0x61626300, `in_bytes`=3, last):
  - Expect one block, W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Expect `blk_first`=`blk_final`=1.
- Empty message (`in_bytes`=0, last):
  - Expect W0=0x80000000, all other words 0.
  - Expect `blk_first`=`blk_final`=1.
- 56-byte message (14 full words, last has `in_bytes`=4):
  - Expect block 1 with W14=0x80000000, W15=0, `blk_final`=0.
  - Expect block 2 with W0..W14=0, W15=0x000001C0, `blk_final`=1.
- 64-byte message:
  - Block 1 is the raw data.
  - Block 2 has W0=0x80000000 and W15=0x00000200.
  - Block 2 `blk_valid` arrives 2 cycles after the block-1 handshake.
- Hold `blk_ready`=0 for 10 cycles on a valid block:
  - `blk_out` and the flags stay constant.
  - `in_ready` stays 0, and no input words are lost.
- Assert `RST`=0 after 7 words of a message:
  - All outputs go to their reset values within the same cycle, asynchronously.
  - A following "abc" message produces the exact block from the first scenario.
